// File: rtl/zigzag_input_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : zigzag_input_pkg
//  Brief    : Shared scancodes, joystick bit positions and coin FSM state type
//             for the ZigZag input stage.
//  Revision : 1.0
// ============================================================================
package zigzag_input_pkg;

    // Arrow keys: the extended flag is not checked for these
    localparam logic [7:0] c_SC_UP      = 8'h75;
    localparam logic [7:0] c_SC_DOWN    = 8'h72;
    localparam logic [7:0] c_SC_LEFT    = 8'h6B;
    localparam logic [7:0] c_SC_RIGHT   = 8'h74;

    // All remaining keys must arrive with the extended flag clear
    localparam logic [7:0] c_SC_FIRE_A  = 8'h29;
    localparam logic [7:0] c_SC_FIRE_B  = 8'h14;
    localparam logic [7:0] c_SC_F1      = 8'h05;
    localparam logic [7:0] c_SC_F2      = 8'h06;
    localparam logic [7:0] c_SC_1       = 8'h16;
    localparam logic [7:0] c_SC_2       = 8'h1E;
    localparam logic [7:0] c_SC_COIN_A  = 8'h2E;
    localparam logic [7:0] c_SC_COIN_B  = 8'h36;
    localparam logic [7:0] c_SC_P2_UP   = 8'h2D;
    localparam logic [7:0] c_SC_P2_DOWN = 8'h2B;
    localparam logic [7:0] c_SC_P2_LEFT = 8'h23;
    localparam logic [7:0] c_SC_P2_RGHT = 8'h34;
    localparam logic [7:0] c_SC_P2_FIRE = 8'h1C;
    localparam logic [7:0] c_SC_TEST    = 8'h2C;

    localparam int c_JOY_R      = 0;
    localparam int c_JOY_L      = 1;
    localparam int c_JOY_D      = 2;
    localparam int c_JOY_U      = 3;
    localparam int c_JOY_FIRE   = 4;
    localparam int c_JOY_START1 = 5;
    localparam int c_JOY_START2 = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

endpackage
`default_nettype wire

// File: rtl/zigzag_input_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : zigzag_input_ctrl_if
//  Brief    : Host-side key/joystick inputs and decoded core controls.
//  Revision : 1.0
// ============================================================================
interface zigzag_input_ctrl_if;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        no_rotate;
    logic        up, down, left, right, fire;
    logic        up2, down2, left2, right2, fire2;
    logic        start1, start2;
    logic        coin;
    logic        test;

    modport master (
        output ps2_key, joystick_0, joystick_1, no_rotate,
        input  up, down, left, right, fire,
        input  up2, down2, left2, right2, fire2,
        input  start1, start2, coin, test
    );

    modport slave (
        input  ps2_key, joystick_0, joystick_1, no_rotate,
        output up, down, left, right, fire,
        output up2, down2, left2, right2, fire2,
        output start1, start2, coin, test
    );
endinterface
`default_nettype wire

// File: rtl/zigzag_input_ctrl_coin_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : coin_pulse_gen
//  Brief    : Turns rising edges of a coin request into fixed-width pulses
//             separated by a guaranteed low gap; one edge may be queued.
//  Revision : 1.0
// ============================================================================
module coin_pulse_gen
    import zigzag_input_pkg::*;
#(
    parameter int COIN_PULSE = 1_200_000,
    parameter int COIN_GAP   = 1_200_000,
    parameter int CNT_W      = 21
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic i_req,
    output logic o_coin
);
    logic              r_req, r_req_d;
    logic              w_edge;
    coin_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_pending, w_pending_nxt;

    assign w_edge = r_req & ~r_req_d;
    assign o_coin = (r_state == PULSE);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_req     <= 1'b0;
            r_req_d   <= 1'b0;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            r_req     <= i_req;
            r_req_d   <= r_req;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // An edge arriving on the very cycle IDLE is left is absorbed by that pulse
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pending_nxt = r_pending;
        case (r_state)
            IDLE: begin
                if (w_edge || r_pending) begin
                    w_state_nxt   = PULSE;
                    w_cnt_nxt     = '0;
                    w_pending_nxt = 1'b0;
                end
            end
            PULSE: begin
                if (w_edge) w_pending_nxt = 1'b1;
                if (r_cnt == CNT_W'(COIN_PULSE - 1)) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (w_edge) w_pending_nxt = 1'b1;
                if (r_cnt == CNT_W'(COIN_GAP - 1)) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/zigzag_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : zigzag_input_ctrl
//  Brief    : Decodes PS/2 key events and both joysticks into registered
//             per-player controls with orientation remap and coin shaping.
//  Revision : 1.0
// ============================================================================
module zigzag_input_ctrl
    import zigzag_input_pkg::*;
#(
    parameter int COIN_PULSE = 1_200_000,
    parameter int COIN_GAP   = 1_200_000,
    parameter int CNT_W      = 21
) (
    input  logic               clk_sys,
    input  logic               reset,
    zigzag_input_ctrl_if.slave bus
);
    logic       w_strobe, w_pressed, w_ext, w_event, w_std_event;
    logic [7:0] w_code;
    logic       r_primed, r_toggle;

    logic r_k_up, r_k_down, r_k_left, r_k_right, r_k_fire;
    logic r_k_up2, r_k_down2, r_k_left2, r_k_right2, r_k_fire2;
    logic r_k_start1, r_k_start2, r_k_coin, r_k_test;

    assign w_strobe    = bus.ps2_key[10];
    assign w_pressed   = bus.ps2_key[9];
    assign w_ext       = bus.ps2_key[8];
    assign w_code      = bus.ps2_key[7:0];
    // Until primed, the tracker only samples the strobe so reset never fakes an event
    assign w_event     = r_primed & (w_strobe != r_toggle);
    assign w_std_event = w_event & ~w_ext;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_primed   <= 1'b0;
            r_toggle   <= 1'b0;
            r_k_up     <= 1'b0;
            r_k_down   <= 1'b0;
            r_k_left   <= 1'b0;
            r_k_right  <= 1'b0;
            r_k_fire   <= 1'b0;
            r_k_up2    <= 1'b0;
            r_k_down2  <= 1'b0;
            r_k_left2  <= 1'b0;
            r_k_right2 <= 1'b0;
            r_k_fire2  <= 1'b0;
            r_k_start1 <= 1'b0;
            r_k_start2 <= 1'b0;
            r_k_coin   <= 1'b0;
            r_k_test   <= 1'b0;
        end else begin
            r_primed <= 1'b1;
            r_toggle <= w_strobe;
            if (w_event) begin
                case (w_code)
                    c_SC_UP:    r_k_up    <= w_pressed;
                    c_SC_DOWN:  r_k_down  <= w_pressed;
                    c_SC_LEFT:  r_k_left  <= w_pressed;
                    c_SC_RIGHT: r_k_right <= w_pressed;
                    default: ;
                endcase
            end
            if (w_std_event) begin
                case (w_code)
                    c_SC_FIRE_A, c_SC_FIRE_B: r_k_fire   <= w_pressed;
                    c_SC_F1, c_SC_1:          r_k_start1 <= w_pressed;
                    c_SC_F2, c_SC_2:          r_k_start2 <= w_pressed;
                    c_SC_COIN_A, c_SC_COIN_B: r_k_coin   <= w_pressed;
                    c_SC_P2_UP:               r_k_up2    <= w_pressed;
                    c_SC_P2_DOWN:             r_k_down2  <= w_pressed;
                    c_SC_P2_LEFT:             r_k_left2  <= w_pressed;
                    c_SC_P2_RGHT:             r_k_right2 <= w_pressed;
                    c_SC_P2_FIRE:             r_k_fire2  <= w_pressed;
                    c_SC_TEST:                r_k_test   <= w_pressed;
                    default: ;
                endcase
            end
        end
    end

    logic w_u1, w_d1, w_l1, w_r1, w_u2, w_d2, w_l2, w_r2;
    logic w_start1, w_start2, w_coin_req;
    logic w_unused_joy;

    assign w_u1 = r_k_up     | bus.joystick_0[c_JOY_U];
    assign w_d1 = r_k_down   | bus.joystick_0[c_JOY_D];
    assign w_l1 = r_k_left   | bus.joystick_0[c_JOY_L];
    assign w_r1 = r_k_right  | bus.joystick_0[c_JOY_R];
    assign w_u2 = r_k_up2    | bus.joystick_1[c_JOY_U];
    assign w_d2 = r_k_down2  | bus.joystick_1[c_JOY_D];
    assign w_l2 = r_k_left2  | bus.joystick_1[c_JOY_L];
    assign w_r2 = r_k_right2 | bus.joystick_1[c_JOY_R];

    assign w_start1   = r_k_start1 | bus.joystick_0[c_JOY_START1] | bus.joystick_1[c_JOY_START1];
    assign w_start2   = r_k_start2 | bus.joystick_0[c_JOY_START2] | bus.joystick_1[c_JOY_START2];
    // Pressing start also drops a coin so a single button begins a game
    assign w_coin_req = r_k_coin | w_start1 | w_start2;

    assign w_unused_joy = ^{bus.joystick_0[15:7], bus.joystick_1[15:7]};

    logic r_up, r_down, r_left, r_right, r_fire;
    logic r_up2, r_down2, r_left2, r_right2, r_fire2;
    logic r_start1, r_start2, r_test;

    // Horizontal cabinet: stick rotated a quarter turn relative to the screen
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_up     <= 1'b0;
            r_down   <= 1'b0;
            r_left   <= 1'b0;
            r_right  <= 1'b0;
            r_fire   <= 1'b0;
            r_up2    <= 1'b0;
            r_down2  <= 1'b0;
            r_left2  <= 1'b0;
            r_right2 <= 1'b0;
            r_fire2  <= 1'b0;
            r_start1 <= 1'b0;
            r_start2 <= 1'b0;
            r_test   <= 1'b0;
        end else begin
            r_up     <= bus.no_rotate ? w_l1 : w_u1;
            r_down   <= bus.no_rotate ? w_r1 : w_d1;
            r_left   <= bus.no_rotate ? w_d1 : w_l1;
            r_right  <= bus.no_rotate ? w_u1 : w_r1;
            r_up2    <= bus.no_rotate ? w_l2 : w_u2;
            r_down2  <= bus.no_rotate ? w_r2 : w_d2;
            r_left2  <= bus.no_rotate ? w_d2 : w_l2;
            r_right2 <= bus.no_rotate ? w_u2 : w_r2;
            r_fire   <= r_k_fire  | bus.joystick_0[c_JOY_FIRE];
            r_fire2  <= r_k_fire2 | bus.joystick_1[c_JOY_FIRE];
            r_start1 <= w_start1;
            r_start2 <= w_start2;
            r_test   <= r_k_test;
        end
    end

    assign bus.up     = r_up;
    assign bus.down   = r_down;
    assign bus.left   = r_left;
    assign bus.right  = r_right;
    assign bus.fire   = r_fire;
    assign bus.up2    = r_up2;
    assign bus.down2  = r_down2;
    assign bus.left2  = r_left2;
    assign bus.right2 = r_right2;
    assign bus.fire2  = r_fire2;
    assign bus.start1 = r_start1;
    assign bus.start2 = r_start2;
    assign bus.test   = r_test;

    coin_pulse_gen #(
        .COIN_PULSE (COIN_PULSE),
        .COIN_GAP   (COIN_GAP),
        .CNT_W      (CNT_W)
    ) u_coin (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_req   (w_coin_req),
        .o_coin  (bus.coin)
    );
endmodule
`default_nettype wire

// File: tb/tb_zigzag_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zigzag_input_ctrl
//  Brief    : Directed self-checking bench for zigzag_input_ctrl.
//  Revision : 1.0
// ============================================================================
module tb_zigzag_input_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] pat;

    zigzag_input_ctrl_if bus();

    zigzag_input_ctrl #(
        .COIN_PULSE (4),
        .COIN_GAP   (3),
        .CNT_W      (4)
    ) dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic key_evt(input logic p, input logic e, input logic [7:0] code);
        bus.ps2_key = {~bus.ps2_key[10], p, e, code};
    endtask

    // {up,down,left,right,fire,up2,down2,left2,right2,fire2,start1,start2,test}
    function automatic logic [31:0] outs();
        return {19'd0, bus.up, bus.down, bus.left, bus.right, bus.fire,
                bus.up2, bus.down2, bus.left2, bus.right2, bus.fire2,
                bus.start1, bus.start2, bus.test};
    endfunction

    initial begin
        rst            = 1'b1;
        bus.ps2_key    = {1'b1, 1'b1, 1'b0, 8'h75};
        bus.joystick_0 = 16'h0000;
        bus.joystick_1 = 16'h0000;
        bus.no_rotate  = 1'b0;
        tick(); tick();
        chk("reset_outs", outs(), 32'h0);
        chk("reset_coin", {31'd0, bus.coin}, 32'h0);
        rst = 1'b0;
        repeat (3) tick();
        chk("post_reset_no_spurious", outs(), 32'h0);

        // Key decode: key register then output register
        key_evt(1'b1, 1'b0, 8'h75); tick();
        chk("up_latency_1", outs(), 32'h0);
        tick();
        chk("key_up_press", outs(), 32'h1000);
        key_evt(1'b0, 1'b0, 8'h75); tick(); tick();
        chk("key_up_release", outs(), 32'h0);
        bus.ps2_key[9] = 1'b1; tick(); tick();
        chk("no_toggle_no_event", outs(), 32'h0);
        key_evt(1'b1, 1'b0, 8'h72); tick(); tick();
        chk("key_down_press", outs(), 32'h0800);
        key_evt(1'b0, 1'b0, 8'h72); tick(); tick();
        key_evt(1'b1, 1'b1, 8'h6B); tick(); tick();
        chk("key_left_ext", outs(), 32'h0400);
        key_evt(1'b0, 1'b1, 8'h6B); tick(); tick();
        key_evt(1'b1, 1'b1, 8'h29); tick(); tick();
        chk("ext_fire_ignored", outs(), 32'h0);
        key_evt(1'b1, 1'b0, 8'h14); tick(); tick();
        chk("key_fire_14", outs(), 32'h0100);
        key_evt(1'b0, 1'b0, 8'h14); tick(); tick();
        key_evt(1'b1, 1'b0, 8'h2D); tick(); tick();
        chk("key_p2_up", outs(), 32'h0080);
        key_evt(1'b0, 1'b0, 8'h2D); tick(); tick();
        key_evt(1'b1, 1'b0, 8'h2C); tick(); tick();
        chk("key_test", outs(), 32'h0001);
        key_evt(1'b0, 1'b0, 8'h2C); tick(); tick();

        // Rotation of player 1 joystick
        bus.no_rotate = 1'b1; bus.joystick_0 = 16'h0008; tick();
        chk("rotate_up_to_right", outs(), 32'h0200);
        bus.no_rotate = 1'b0; tick();
        chk("rotate_off_up", outs(), 32'h1000);
        bus.joystick_0 = 16'h0000; tick();
        chk("joy_release", outs(), 32'h0);

        // Held coin key: single 4-cycle pulse, three cycles after the toggle
        pat = '0;
        key_evt(1'b1, 1'b0, 8'h2E);
        for (int t = 1; t <= 20; t++) begin
            tick(); pat[t] = bus.coin;
        end
        chk("coin_held_single", pat, 32'h0000_0078);
        key_evt(1'b0, 1'b0, 8'h2E); repeat (12) tick();

        // Second edge during GAP: queued pulse right after GAP
        pat = '0;
        key_evt(1'b1, 1'b0, 8'h36);
        for (int t = 1; t <= 24; t++) begin
            tick(); pat[t] = bus.coin;
            if (t == 4) key_evt(1'b0, 1'b0, 8'h36);
            if (t == 6) key_evt(1'b1, 1'b0, 8'h36);
        end
        chk("coin_gap_pending", pat, 32'h0000_7878);
        key_evt(1'b0, 1'b0, 8'h36); repeat (12) tick();

        // Several edges during one pulse/gap: only one extra pulse
        pat = '0;
        key_evt(1'b1, 1'b0, 8'h2E);
        for (int t = 1; t <= 28; t++) begin
            tick(); pat[t] = bus.coin;
            if (t <= 7) key_evt((t % 2) == 0, 1'b0, 8'h2E);
        end
        chk("coin_multi_edge_saturate", pat, 32'h0000_7878);
        repeat (12) tick();

        // Start from player 2 stick inserts one coin
        pat = '0;
        bus.joystick_1 = 16'h0020; tick();
        chk("start1_joy1", outs(), 32'h0004);
        pat[1] = bus.coin;
        for (int t = 2; t <= 16; t++) begin
            tick(); pat[t] = bus.coin;
        end
        chk("start_coin_single", pat, 32'h0000_003C);
        bus.joystick_1 = 16'h0000; tick();
        chk("start1_release", outs(), 32'h0);
        repeat (12) tick();

        // Player 2 stick, straight and rotated
        bus.joystick_1 = 16'h001F; tick();
        chk("p2_joy_all", outs(), 32'h00F8);
        bus.no_rotate = 1'b1; bus.joystick_1 = 16'h0001; tick();
        chk("p2_rotate_right_to_down", outs(), 32'h0040);
        bus.no_rotate = 1'b0; bus.joystick_1 = 16'h0000; tick();

        // Reset mid-pulse
        bus.joystick_0 = 16'h0010;
        key_evt(1'b1, 1'b0, 8'h2E);
        repeat (4) tick();
        chk("coin_before_reset", {31'd0, bus.coin}, 32'h1);
        chk("fire_before_reset", outs(), 32'h0100);
        rst = 1'b1; #1;
        chk("reset_async_coin", {31'd0, bus.coin}, 32'h0);
        chk("reset_async_outs", outs(), 32'h0);
        bus.ps2_key = {~bus.ps2_key[10], 1'b1, 1'b0, 8'h2E};
        tick(); tick();
        rst = 1'b0;
        pat = '0;
        for (int t = 1; t <= 12; t++) begin
            tick(); pat[t] = bus.coin;
        end
        chk("post_reset_no_coin", pat, 32'h0);
        chk("post_reset_fire", outs(), 32'h0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
